// File: rtl/rx_hsk_fifo_pkg.sv
// rx_hsk_fifo_pkg: shared FSM encodings and depth helper for rx_hsk_fifo.
package rx_hsk_fifo_pkg;
    typedef enum logic {W_IDLE = 1'b0, W_ACK = 1'b1} w_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_WAIT = 2'd2} r_state_e;
    localparam int DEPTH_LOG2_DEF = 4;
    localparam int DEPTH = 1 << DEPTH_LOG2_DEF;
    function automatic int depth_of(input int log2);
        return 1 << log2;
    endfunction
endpackage

// File: rtl/rx_hsk_fifo_mem.sv
// rx_hsk_fifo_mem: DEPTH x DATA_W register array, synchronous write, combinational read.
module rx_hsk_fifo_mem
    import rx_hsk_fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  in_clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);
    logic [DATA_W-1:0] mem_q [depth_of(DEPTH_LOG2)];
    always_ff @(posedge in_clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/rx_hsk_fifo.sv
// rx_hsk_fifo: 4-phase req/ack byte FIFO between the FT245 RX side and the protocol engine.
// Define RX_HSK_FIFO_LEVEL_EN to expose out_level and the sticky high-water mark out_hwm.
module rx_hsk_fifo
    import rx_hsk_fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_wr_req,
    input  logic [DATA_W-1:0] in_wr_data,
    output logic              out_wr_ack,
    output logic              out_rx_en,
    output logic              out_rd_req,
    output logic [DATA_W-1:0] out_rd_data,
    input  logic              in_rd_ack
`ifdef RX_HSK_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] out_level,
    output logic [DEPTH_LOG2:0] out_hwm
`endif
);
    localparam int DEPTH = depth_of(DEPTH_LOG2);
    localparam int CW    = DEPTH_LOG2 + 1;

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ack_q, wr_ack_d, rd_req_q, rd_req_d, rx_en_q, rx_en_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d, mem_rd;
    logic                  full, empty, push, pop;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;

    rx_hsk_fifo_mem #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .in_clk  (in_clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rd)
    );

    always_comb begin
        w_state_d = w_state_q;
        wr_ack_d  = wr_ack_q;
        push      = 1'b0;
        if (w_state_q == W_IDLE) begin
            if (in_wr_req && !full) begin
                push      = 1'b1;
                w_state_d = W_ACK;
                wr_ack_d  = 1'b1;
            end
        end else if (!in_wr_req) begin
            w_state_d = W_IDLE;
            wr_ack_d  = 1'b0;
        end
        r_state_d = r_state_q;
        rd_req_d  = rd_req_q;
        rd_data_d = rd_data_q;
        pop       = 1'b0;
        case (r_state_q)
            R_IDLE: if (!empty) begin
                rd_data_d = mem_rd;
                rd_req_d  = 1'b1;
                r_state_d = R_REQ;
            end
            R_REQ: if (in_rd_ack) begin
                pop       = 1'b1;
                rd_req_d  = 1'b0;
                r_state_d = R_WAIT;
            end
            default: r_state_d = in_rd_ack ? R_WAIT : R_IDLE;
        endcase
        count_d = count_q + CW'(push) - CW'(pop);
        rx_en_d = count_d < CW'(DEPTH - AF_MARGIN);
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_ack_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            rd_data_q <= '0;
            rx_en_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            wr_ptr_q  <= wr_ptr_q + DEPTH_LOG2'(push);
            rd_ptr_q  <= rd_ptr_q + DEPTH_LOG2'(pop);
            count_q   <= count_d;
            wr_ack_q  <= wr_ack_d;
            rd_req_q  <= rd_req_d;
            rd_data_q <= rd_data_d;
            rx_en_q   <= rx_en_d;
        end
    end

    assign out_wr_ack  = wr_ack_q;
    assign out_rd_req  = rd_req_q;
    assign out_rd_data = rd_data_q;
    assign out_rx_en   = rx_en_q;

`ifdef RX_HSK_FIFO_LEVEL_EN
    logic [CW-1:0] hwm_q;
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) hwm_q <= '0;
        else hwm_q <= (count_d > hwm_q) ? count_d : hwm_q;
    end
    assign out_level = count_q;
    assign out_hwm   = hwm_q;
`endif
endmodule
